// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states,
// ALU operation and datapath mux select values.
package mips_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  // Controller states; the encoding is visible on state_o for debug
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_REX     = 4'd6,
    ST_RWB     = 4'd7,
    ST_BEQ     = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_TRAP    = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and run the timeout counter
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory-ready handshake, wait timeout,
// illegal-opcode trap and a retired-instruction counter. Control outputs
// are decoded combinationally from the registered state.
module mc_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter bit          EN_ADDI = 1'b1,
  parameter bit          EN_J    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [1:0]       alu_op,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired,
  output logic             exc_illegal,
  output logic             exc_timeout
);

  state_t            r_state;
  state_t            w_state_next;
  logic [TO_W-1:0]   r_wait_cnt;
  logic [TO_W-1:0]   w_wait_cnt_next;
  logic [CNT_W-1:0]  r_retired;
  logic              r_exc_illegal;
  logic              r_exc_timeout;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_retire;
  logic              w_is_wait;
  logic              w_timeout;
  logic              w_mem_write;
  logic              w_reg_write;

  // A wait state times out when the counter is saturated and memory is still
  // not ready; a ready on that same cycle takes priority.
  assign w_is_wait = is_wait_state(r_state);
  assign w_timeout = w_is_wait && !mem_ready && (&r_wait_cnt);

  // Wait counter counts consecutive not-ready cycles and clears otherwise
  assign w_wait_cnt_next = (w_is_wait && !mem_ready && !w_timeout)
                           ? r_wait_cnt + 1'b1 : '0;

  // State register and the counters/sticky flags that follow it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_wait_cnt    <= '0;
      r_retired     <= '0;
      r_exc_illegal <= 1'b0;
      r_exc_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_retire)      r_retired     <= r_retired + 1'b1;
      if (w_set_illegal) r_exc_illegal <= 1'b1;
      if (w_set_timeout) r_exc_timeout <= 1'b1;
    end
  end

  // Next-state selection and Moore control decode, all defaults first
  always_comb begin
    w_state_next  = r_state;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    w_retire      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_srca      = 1'b0;
    alu_srcb      = SRCB_REGB;
    alu_op        = ALU_ADD;
    iord          = 1'b0;
    mem_read      = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        mem_read = 1'b1;
        alu_srcb = SRCB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (w_timeout) begin
          w_state_next  = ST_TRAP;
          w_set_timeout = 1'b1;
        end else if (mem_ready) begin
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch target is computed here, before the opcode is known
        alu_srcb = SRCB_BR;
        case (opcode)
          OPC_LW, OPC_SW: w_state_next = ST_MEMADR;
          OPC_RTYPE:      w_state_next = ST_REX;
          OPC_BEQ:        w_state_next = ST_BEQ;
          OPC_ADDI: begin
            if (EN_ADDI) begin
              w_state_next = ST_ADDIEX;
            end else begin
              w_state_next  = ST_TRAP;
              w_set_illegal = 1'b1;
            end
          end
          OPC_J: begin
            if (EN_J) begin
              w_state_next = ST_JUMP;
            end else begin
              w_state_next  = ST_TRAP;
              w_set_illegal = 1'b1;
            end
          end
          default: begin
            w_state_next  = ST_TRAP;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_srca     = 1'b1;
        alu_srcb     = SRCB_IMM;
        w_state_next = (opcode == OPC_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (w_timeout) begin
          w_state_next  = ST_TRAP;
          w_set_timeout = 1'b1;
        end else if (mem_ready) begin
          w_state_next = ST_MEMWB;
        end
      end
      ST_MEMWB: begin
        w_reg_write  = 1'b1;
        mem_to_reg   = 1'b1;
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_MEMWR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
        if (w_timeout) begin
          w_state_next  = ST_TRAP;
          w_set_timeout = 1'b1;
        end else if (mem_ready) begin
          w_state_next = ST_FETCH;
          w_retire     = 1'b1;
        end
      end
      ST_REX: begin
        alu_srca     = 1'b1;
        alu_op       = ALU_FUNCT;
        w_state_next = ST_RWB;
      end
      ST_RWB: begin
        w_reg_write  = 1'b1;
        reg_dst      = 1'b1;
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_BEQ: begin
        alu_srca     = 1'b1;
        alu_op       = ALU_SUB;
        pc_src       = PCSRC_ALUOUT;
        pc_write     = zero;
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_ADDIEX: begin
        alu_srca     = 1'b1;
        alu_srcb     = SRCB_IMM;
        w_state_next = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_JUMP: begin
        pc_src       = PCSRC_JUMP;
        pc_write     = 1'b1;
        w_state_next = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_TRAP: begin
        w_state_next = ST_TRAP;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // Architectural writes are blocked as soon as reset rises, so an aborted
  // instruction cannot commit during the cycle before the reset edge.
  assign mem_write = w_mem_write & ~reset;
  assign reg_write = w_reg_write & ~reset;

  assign state_o     = r_state;
  assign retired     = r_retired;
  assign exc_illegal = r_exc_illegal;
  assign exc_timeout = r_exc_timeout;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm. Instance a uses default parameters;
// instance b uses TO_W=2, CNT_W=2, EN_ADDI=0 and shares all inputs.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        a_ir_write, a_pc_write, a_alu_srca, a_iord, a_mem_read;
  logic        a_mem_write, a_reg_write, a_reg_dst, a_mem_to_reg;
  logic [1:0]  a_pc_src, a_alu_srcb, a_alu_op;
  logic [3:0]  a_state;
  logic [31:0] a_retired;
  logic        a_exc_illegal, a_exc_timeout;

  logic        b_ir_write, b_pc_write, b_alu_srca, b_iord, b_mem_read;
  logic        b_mem_write, b_reg_write, b_reg_dst, b_mem_to_reg;
  logic [1:0]  b_pc_src, b_alu_srcb, b_alu_op;
  logic [3:0]  b_state;
  logic [1:0]  b_retired;
  logic        b_exc_illegal, b_exc_timeout;

  // {ir_write,pc_write,pc_src,srca,srcb,alu_op,iord,mem_read,mem_write,reg_write,reg_dst,mem_to_reg}
  logic [14:0] a_ctl, b_ctl, exp_ctl;

  int n_total = 0;
  int n_pass  = 0;

  assign a_ctl = {a_ir_write, a_pc_write, a_pc_src, a_alu_srca, a_alu_srcb, a_alu_op,
                  a_iord, a_mem_read, a_mem_write, a_reg_write, a_reg_dst, a_mem_to_reg};
  assign b_ctl = {b_ir_write, b_pc_write, b_pc_src, b_alu_srca, b_alu_srcb, b_alu_op,
                  b_iord, b_mem_read, b_mem_write, b_reg_write, b_reg_dst, b_mem_to_reg};

  mc_ctrl_fsm dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_srca(a_alu_srca), .alu_srcb(a_alu_srcb), .alu_op(a_alu_op),
    .iord(a_iord), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .state_o(a_state), .retired(a_retired),
    .exc_illegal(a_exc_illegal), .exc_timeout(a_exc_timeout)
  );

  mc_ctrl_fsm #(.TO_W(2), .CNT_W(2), .EN_ADDI(1'b0), .EN_J(1'b1)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_srca(b_alu_srca), .alu_srcb(b_alu_srcb), .alu_op(b_alu_op),
    .iord(b_iord), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .state_o(b_state), .retired(b_retired),
    .exc_illegal(b_exc_illegal), .exc_timeout(b_exc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'b000000;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (a_state !== 4'd0) $display("FAIL reset_state got %0d exp 0", a_state);
    else n_pass++;
    n_total++;
    if (a_retired !== 32'd0 || a_exc_illegal !== 1'b0 || a_exc_timeout !== 1'b0)
      $display("FAIL reset_counters got ret=%0d ill=%b to=%b exp 0/0/0",
               a_retired, a_exc_illegal, a_exc_timeout);
    else n_pass++;
    exp_ctl = 15'b0_0_00_0_01_00_0_1_0_0_0_0;
    n_total++;
    if (a_ctl !== exp_ctl) $display("FAIL reset_fetch_ctl got %b exp %b", a_ctl, exp_ctl);
    else n_pass++;
    $display("txn reset done");
  endtask

  task automatic test_r_type();
    do_reset();
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    #1;
    exp_ctl = 15'b1_1_00_0_01_00_0_1_0_0_0_0;
    n_total++;
    if (a_ctl !== exp_ctl) $display("FAIL r_fetch_ctl got %b exp %b", a_ctl, exp_ctl);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_0_11_00_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd1 || a_ctl !== exp_ctl)
      $display("FAIL r_decode got st=%0d ctl=%b exp st=1 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_1_00_10_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd6 || a_ctl !== exp_ctl)
      $display("FAIL r_rex got st=%0d ctl=%b exp st=6 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_0_00_00_0_0_0_1_1_0;
    n_total++;
    if (a_state !== 4'd7 || a_ctl !== exp_ctl)
      $display("FAIL r_rwb got st=%0d ctl=%b exp st=7 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    n_total++;
    if (a_state !== 4'd0 || a_retired !== 32'd1)
      $display("FAIL r_retire got st=%0d ret=%0d exp st=0 ret=1", a_state, a_retired);
    else n_pass++;
    $display("txn R-type retired=%0d", a_retired);
  endtask

  task automatic test_lw_wait();
    do_reset();
    opcode    = 6'b100011;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    exp_ctl = 15'b0_0_00_1_10_00_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd2 || a_ctl !== exp_ctl)
      $display("FAIL lw_memadr got st=%0d ctl=%b exp st=2 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_0_00_00_1_1_0_0_0_0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (a_state !== 4'd3 || a_ctl !== exp_ctl)
        $display("FAIL lw_memrd_wait%0d got st=%0d ctl=%b exp st=3 ctl=%b",
                 i, a_state, a_ctl, exp_ctl);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_total++;
    if (a_state !== 4'd3) $display("FAIL lw_memrd_4th got st=%0d exp 3", a_state);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_0_00_00_0_0_0_1_0_1;
    n_total++;
    if (a_state !== 4'd4 || a_ctl !== exp_ctl)
      $display("FAIL lw_memwb got st=%0d ctl=%b exp st=4 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    n_total++;
    if (a_state !== 4'd0 || a_retired !== 32'd1)
      $display("FAIL lw_retire got st=%0d ret=%0d exp st=0 ret=1", a_state, a_retired);
    else n_pass++;
    $display("txn LW with 3 wait cycles retired=%0d", a_retired);
  endtask

  task automatic test_beq();
    do_reset();
    opcode    = 6'b000100;
    mem_ready = 1'b1;
    zero      = 1'b1;
    tick();
    tick();
    exp_ctl = 15'b0_1_01_1_00_01_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd8 || a_ctl !== exp_ctl)
      $display("FAIL beq_taken got st=%0d ctl=%b exp st=8 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    zero = 1'b0;
    #1;
    exp_ctl = 15'b1_1_00_0_01_00_0_1_0_0_0_0;
    n_total++;
    if (a_state !== 4'd0 || a_ctl !== exp_ctl)
      $display("FAIL beq_back_fetch got st=%0d ctl=%b exp st=0 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (a_state !== 4'd8 || a_pc_write !== 1'b0)
      $display("FAIL beq_not_taken got st=%0d pc_write=%b exp st=8 pc_write=0",
               a_state, a_pc_write);
    else n_pass++;
    tick();
    n_total++;
    if (a_retired !== 32'd2) $display("FAIL beq_retired got %0d exp 2", a_retired);
    else n_pass++;
    $display("txn BEQ x2 retired=%0d", a_retired);
  endtask

  task automatic test_addi_j();
    do_reset();
    opcode    = 6'b001000;
    mem_ready = 1'b1;
    tick();
    tick();
    exp_ctl = 15'b0_0_00_1_10_00_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd9 || a_ctl !== exp_ctl)
      $display("FAIL addi_ex got st=%0d ctl=%b exp st=9 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    n_total++;
    if (b_state !== 4'd12 || b_exc_illegal !== 1'b1 || b_ctl !== 15'd0)
      $display("FAIL addi_disabled_trap got st=%0d ill=%b ctl=%b exp st=12 ill=1 ctl=0",
               b_state, b_exc_illegal, b_ctl);
    else n_pass++;
    tick();
    exp_ctl = 15'b0_0_00_0_00_00_0_0_0_1_0_0;
    n_total++;
    if (a_state !== 4'd10 || a_ctl !== exp_ctl)
      $display("FAIL addi_wb got st=%0d ctl=%b exp st=10 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    opcode = 6'b000010;
    tick();
    tick();
    exp_ctl = 15'b0_1_10_0_00_00_0_0_0_0_0_0;
    n_total++;
    if (a_state !== 4'd11 || a_ctl !== exp_ctl)
      $display("FAIL jump got st=%0d ctl=%b exp st=11 ctl=%b", a_state, a_ctl, exp_ctl);
    else n_pass++;
    tick();
    n_total++;
    if (a_state !== 4'd0 || a_retired !== 32'd2)
      $display("FAIL addi_j_retire got st=%0d ret=%0d exp st=0 ret=2", a_state, a_retired);
    else n_pass++;
    $display("txn ADDI+J retired=%0d", a_retired);
  endtask

  task automatic test_illegal();
    do_reset();
    opcode    = 6'b111111;
    mem_ready = 1'b1;
    tick();
    n_total++;
    if (a_state !== 4'd1 || a_exc_illegal !== 1'b0)
      $display("FAIL ill_decode got st=%0d ill=%b exp st=1 ill=0", a_state, a_exc_illegal);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (a_state !== 4'd12 || a_exc_illegal !== 1'b1 || a_ctl !== 15'd0 || a_exc_timeout !== 1'b0)
        $display("FAIL ill_trap%0d got st=%0d ill=%b to=%b ctl=%b exp st=12 ill=1 to=0 ctl=0",
                 i, a_state, a_exc_illegal, a_exc_timeout, a_ctl);
      else n_pass++;
      tick();
    end
    $display("txn illegal opcode trapped");
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (b_state !== 4'd0) $display("FAIL to_wait%0d got st=%0d exp 0", i, b_state);
      else n_pass++;
    end
    tick();
    n_total++;
    if (b_state !== 4'd12 || b_exc_timeout !== 1'b1 || b_exc_illegal !== 1'b0)
      $display("FAIL to_trap got st=%0d to=%b ill=%b exp st=12 to=1 ill=0",
               b_state, b_exc_timeout, b_exc_illegal);
    else n_pass++;
    n_total++;
    if (a_state !== 4'd0 || a_exc_timeout !== 1'b0)
      $display("FAIL to_wide_no_trap got st=%0d to=%b exp st=0 to=0", a_state, a_exc_timeout);
    else n_pass++;
    $display("txn fetch timeout TO_W=2");
    do_reset();
    tick();
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    n_total++;
    if (b_state !== 4'd1 || b_exc_timeout !== 1'b0)
      $display("FAIL to_ready_wins got st=%0d to=%b exp st=1 to=0", b_state, b_exc_timeout);
    else n_pass++;
    $display("txn ready on saturated counter, no trap");
  endtask

  task automatic test_reset_abort();
    do_reset();
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    repeat (4) tick();
    opcode = 6'b101011;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    exp_ctl = 15'b0_0_00_0_00_00_1_0_1_0_0_0;
    n_total++;
    if (a_state !== 4'd5 || a_ctl !== exp_ctl || a_retired !== 32'd1)
      $display("FAIL sw_memwr got st=%0d ctl=%b ret=%0d exp st=5 ctl=%b ret=1",
               a_state, a_ctl, a_retired, exp_ctl);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (a_mem_write !== 1'b0) $display("FAIL abort_mem_write got %b exp 0", a_mem_write);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_total++;
    if (a_state !== 4'd0 || a_mem_write !== 1'b0 || a_retired !== 32'd0 ||
        a_exc_illegal !== 1'b0 || a_exc_timeout !== 1'b0)
      $display("FAIL abort_state got st=%0d mw=%b ret=%0d ill=%b to=%b exp 0/0/0/0/0",
               a_state, a_mem_write, a_retired, a_exc_illegal, a_exc_timeout);
    else n_pass++;
    $display("txn SW aborted by reset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (4) tick();
      $display("txn back-to-back R %0d retired a=%0d b=%0d", i, a_retired, b_retired);
    end
    n_total++;
    if (a_retired !== 32'd5) $display("FAIL b2b_retired_a got %0d exp 5", a_retired);
    else n_pass++;
    n_total++;
    if (b_retired !== 2'd1) $display("FAIL b2b_retired_wrap got %0d exp 1", b_retired);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_addi_j();
    test_illegal();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
